// File: rtl/hq_norm_acc.sv
// hq_norm_acc: squared-magnitude accumulator for streamed Hq products.
// Each accepted sample is squared (r^2 + i^2, Q16.16). N_ROW squares are
// summed into one norm per Si index. N_SI norms make up one frame, which
// is bracketed by a start pulse and a done pulse.
// Optional feature: define HQ_MIN_TRACK_EN to track the minimum norm of
// the frame and its Si index.
module hq_norm_acc #(
  parameter int DW    = 16,
  parameter int N_ROW = 4,
  parameter int N_SI  = 8,
  parameter int AW    = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hq_valid,
  output logic          hq_ready,
  input  logic [DW-1:0] hq_r,
  input  logic [DW-1:0] hq_i,
  output logic          norm_valid,
  input  logic          norm_ready,
  output logic [31:0]   norm_out,
  output logic [3:0]    norm_idx,
  output logic          done,
  output logic [31:0]   min_norm,
  output logic [3:0]    min_idx
);

  localparam int PW = 2*DW + 1;
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROW - 1);
  localparam logic [3:0]    SI_LAST  = 4'(N_SI - 1);

  typedef enum logic [2:0] {IDLE, ACC, FLUSH, OUT, DONE} state_t;

  state_t               state;
  logic [RW-1:0]        row_cnt;
  logic [3:0]           si_cnt;
  logic [PW-1:0]        p;
  logic                 p_vld;
  logic [AW-1:0]        acc;

  logic signed [2*DW-1:0] r_ext, i_ext, sq_r, sq_i;
  logic [PW-1:0]          p_next;
  logic [31:0]            acc_sat;
  logic                   accept;

  // Full-precision squares; sign-extended first so -32768^2 cannot wrap.
  assign r_ext   = {{DW{hq_r[DW-1]}}, hq_r};
  assign i_ext   = {{DW{hq_i[DW-1]}}, hq_i};
  assign sq_r    = r_ext * r_ext;
  assign sq_i    = i_ext * i_ext;
  assign p_next  = {1'b0, sq_r} + {1'b0, sq_i};
  assign accept  = hq_valid & hq_ready;
  assign acc_sat = (|acc[AW-1:32]) ? 32'hFFFF_FFFF : acc[31:0];

  // Stage 1: register the squared magnitude of each accepted sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p     <= '0;
      p_vld <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) p <= p_next;
    end
  end

  // Control FSM plus stage-2 accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      si_cnt     <= '0;
      acc        <= '0;
      hq_ready   <= 1'b0;
      norm_valid <= 1'b0;
      norm_out   <= '0;
      norm_idx   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (p_vld) acc <= acc + AW'(p);
      case (state)
        IDLE: if (start) begin
          state    <= ACC;
          row_cnt  <= '0;
          si_cnt   <= '0;
          acc      <= '0;
          hq_ready <= 1'b1;
        end
        ACC: if (accept) begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == ROW_LAST) begin
            hq_ready <= 1'b0;
            state    <= FLUSH;
          end
        end
        // Wait until the last square has been added before publishing.
        FLUSH: if (!p_vld) begin
          norm_out   <= acc_sat;
          norm_idx   <= si_cnt;
          norm_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: if (norm_ready) begin
          norm_valid <= 1'b0;
          acc        <= '0;
          row_cnt    <= '0;
          if (si_cnt == SI_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            si_cnt   <= si_cnt + 1'b1;
            hq_ready <= 1'b1;
            state    <= ACC;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HQ_MIN_TRACK_EN
  // Track the smallest norm of the frame; strict compare keeps the lower index on ties.
  always_ff @(posedge clk) begin
    if (!rst) begin
      min_norm <= '0;
      min_idx  <= '0;
    end else if (state == IDLE && start) begin
      min_norm <= '0;
      min_idx  <= '0;
    end else if (state == OUT && norm_ready &&
                 (norm_idx == 4'd0 || norm_out < min_norm)) begin
      min_norm <= norm_out;
      min_idx  <= norm_idx;
    end
  end
`else
  assign min_norm = '0;
  assign min_idx  = '0;
`endif

endmodule

// File: doc/hq_norm_acc.md
Name: hq_norm_acc

Overview:
- Downstream consumer of the streamed Hq products (Q8.8 complex, one sample per row of H per Si candidate) in the SOML decoder.
- Accepts Hq samples through a valid/ready handshake and computes the squared magnitude r^2 + i^2 of each sample.
- Accumulates N_ROW samples per Si index and hands one norm per Si to the detector stage through a valid/ready handshake.
- Frames of N_SI norms are started by a start pulse and end with a done pulse.

Parameters:
- DW, 16, sample width in bits (signed two's complement, Q8.8).
- N_ROW, 4, Hq samples accumulated per Si index.
- N_SI, 8, Si indices per frame (max 16).
- AW, 34, internal accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  frame start pulse; ignored unless in IDLE.
- hq_valid  in  1  sample valid.
- hq_ready  out  1  sample accepted when hq_valid & hq_ready.
- hq_r  in  DW  real part, signed Q8.8.
- hq_i  in  DW  imaginary part, signed Q8.8.
- norm_valid  out  1  norm output valid.
- norm_ready  in  1  downstream accept.
- norm_out  out  32  accumulated |Hq|^2, unsigned Q16.16, saturated.
- norm_idx  out  4  Si index of norm_out (0..N_SI-1).
- done  out  1  one-cycle pulse when the frame's last norm is accepted.
- min_norm  out  32  minimum norm of the frame (optional feature).
- min_idx  out  4  Si index of min_norm (optional feature).

Behaviour:
- Reset (rst=0 at clock edge), all states: state=IDLE; all counters, accumulator and pipeline registers cleared; hq_ready=0, norm_valid=0, norm_out=0, norm_idx=0, done=0, min_norm=0, min_idx=0. Reset mid-frame discards all partial results.
- FSM states IDLE, ACC, FLUSH, OUT, DONE.
- IDLE: on start=1 -> ACC with row_cnt=0, si_cnt=0, accumulator=0.
- ACC: hq_ready=1. Each accepted sample is squared into stage-1 register P = hq_r*hq_r + hq_i*hq_i as an unsigned 33-bit Q16.16 value. P is added into the AW-bit accumulator one cycle later. Each accept increments row_cnt. When the N_ROW-th sample is accepted, hq_ready drops the next cycle -> FLUSH.
- FLUSH: one cycle for the final add to land. Then:
  - norm_out = accumulator saturated to 0xFFFFFFFF if it exceeds 32 bits.
  - norm_idx = si_cnt.
  - norm_valid=1 -> OUT.
- Latency: norm_valid rises 2 cycles after the last accepting edge of the group.
- OUT: norm_out and norm_idx are held stable while norm_valid=1 and norm_ready=0. On norm_ready=1:
  - norm_valid=0; accumulator and row_cnt cleared.
  - If si_cnt == N_SI-1 -> DONE, else si_cnt+1 -> ACC.
- DONE: done=1 for exactly one cycle -> IDLE.
- hq_ready=0 in IDLE, FLUSH, OUT and DONE; hq_valid in those states is ignored and no sample is consumed.
- start asserted outside IDLE is ignored.
- hq_valid may toggle arbitrarily in ACC; only accepting edges advance row_cnt.
- Bubbles are allowed, and samples for the next Si are never accepted before the current norm is handed off.
- Arithmetic: squares computed at full signed 2*DW precision. -32768^2 = 0x40000000 is representable; there is no intermediate wrap.

Optional Feature:
- Macro: HQ_MIN_TRACK_EN.
- When defined: at each norm handoff in OUT, if it is the first norm of the frame, or norm_out < min_norm (strict), then min_norm <= norm_out and min_idx <= norm_idx. Ties keep the lower index. Both values are valid from the done pulse until the next start, and are cleared on start.
- When undefined: min_norm and min_idx are tied to 0 and no compare logic is built.

Test Plan:
- N_ROW=4, N_SI=1; start, then 4 samples hq_r=0x0100, hq_i=0x0000, hq_valid held high, norm_ready=1 -> norm_out=0x00040000, norm_idx=0, norm_valid 2 cycles after the 4th accept, done 1 cycle after the handoff.
- 4 samples hq_r=0x8000, hq_i=0x8000 -> per-sample P=0x80000000; sum 0x200000000 saturates -> norm_out=0xFFFFFFFF.
- N_SI=2, norm_ready=0 for 5 cycles after norm_valid -> norm_out/norm_idx stable, hq_ready=0, and extra hq_valid samples are not consumed. Release -> norm_idx=1 group accumulates only new samples.
- hq_valid toggling 1,0,0,1,0,1,1 in ACC with samples 0x0080 real (0.5, P=0x4000) -> exactly 4 accepts, norm_out=0x00010000.
- rst=0 for one cycle after the 2nd sample of a group -> all outputs 0, state IDLE. Next frame after start matches a clean run.
- HQ_MIN_TRACK_EN defined, N_SI=3, norms 0x30000, 0x10000, 0x10000 -> at done, min_norm=0x00010000 and min_idx=1.
